ts_mux_n: RTL and testbench
===========================

Name: ts_mux_n

Overview:
- N-channel MPEG-TS packet multiplexer, successor to the fixed 4-input muxer; channel count, packet length and buffer depth are parametrised.
- Per-channel packet buffers accept parallel TS byte streams, already synchronised to CLK.
- A packet-granular round-robin scheduler emits whole packets onto one 8-bit output stream, paced by an external byte-slot strobe.
- Sits between the tuner/generator front-ends and the output TS interface.

Parameters:
- N_CH, 4, number of input channels (2..16).
- PKT_LEN, 188, bytes per TS packet.
- BUF_PKTS, 2, whole packets of storage per channel.

Ports:
- CLK  in  1  system clock; all logic is on this single clock.
- RST  in  1  synchronous, active-high reset.
- DATA_IN  in  8*N_CH  input bytes; channel k occupies bits [8k+7:8k].
- D_VALID_IN  in  N_CH  per-channel byte-valid strobe.
- P_SYNC_IN  in  N_CH  per-channel first-byte-of-packet flag; qualified by D_VALID_IN.
- OUT_EN  in  1  output byte slot; one byte is emitted per OUT_EN cycle.
- DATA_OUT  out  8  output byte.
- D_VALID_OUT  out  1  DATA_OUT is valid.
- P_SYNC_OUT  out  1  DATA_OUT is the first byte of a packet.
- CH_OUT  out  clog2(N_CH)  source channel of the current packet.
- OVERFLOW  out  N_CH  sticky per-channel packet-drop flag; cleared only by RST.

Behaviour:
- Reset values: DATA_OUT=0, D_VALID_OUT=0, P_SYNC_OUT=0, CH_OUT=0, OVERFLOW=0. All buffers are emptied and the round-robin pointer is set to channel 0. Reset mid-packet truncates the output packet with no tail bytes.
- Input assembler, per channel; states IDLE, FILL.
  - IDLE: D_VALID&P_SYNC with free space >= PKT_LEN -> write byte, go to FILL, byte count=1.
  - IDLE: D_VALID&P_SYNC with free space < PKT_LEN -> drop the whole packet, set OVERFLOW[k], stay in IDLE and ignore bytes up to the next P_SYNC.
  - IDLE: D_VALID without P_SYNC -> byte ignored.
  - FILL: D_VALID without P_SYNC -> write byte. On byte PKT_LEN: commit the packet (packet count +1), go to IDLE.
  - FILL: D_VALID&P_SYNC -> discard the partial packet (rewind the tentative write pointer to the commit pointer), then handle the byte as an IDLE start in the same cycle.
- Buffer: circular, BUF_PKTS*PKT_LEN bytes. Uses a tentative write pointer, a commit pointer and a read pointer. Only committed packets are visible to the scheduler.
- Scheduler states: IDLE, SEND.
  - IDLE, OUT_EN high: grant the first channel with packet count >= 1, searching from the RR pointer upward with wrap. Go to SEND and emit byte 0 on that same OUT_EN.
  - IDLE, no channel ready: D_VALID_OUT=0.
  - SEND: one byte per OUT_EN. The byte counter wraps 0..PKT_LEN-1.
  - SEND, after byte PKT_LEN-1: decrement the packet count, set the RR pointer to granted+1 mod N_CH, go to IDLE.
  - An idle slot costs no extra cycle: a back-to-back OUT_EN continues with the next packet's byte 0.
- Output timing: outputs are registered and update the cycle after OUT_EN. On cycles without OUT_EN, D_VALID_OUT and P_SYNC_OUT are 0 and DATA_OUT holds its value.
- P_SYNC_OUT=1 on byte 0 only. CH_OUT is stable for the whole packet.
- Simultaneous commit and read-complete on one channel: packet count is unchanged.
- A channel may be written and read in the same cycle; pointers are independent.
- The output never interleaves channels inside a packet.

Optional Feature:
- Macro: TS_NULL_INSERT_EN.
- Defined: on an IDLE OUT_EN with no channel ready, emit a null packet of PKT_LEN bytes.
  - Header bytes 47 1F FF 10, then FF padding.
  - P_SYNC_OUT=1 on the 47 byte; CH_OUT=0.
  - The RR pointer is not advanced.
- Not defined: idle slots emit nothing (D_VALID_OUT=0), as above.

Decomposition:
- Package ts_mux_pkg holds:
  - TS_SYNC_BYTE=8'h47.
  - TS_NULL_PID=13'h1FFF.
  - The null-header constants.
  - The assembler and scheduler state enums.
  - A clog2 helper.
- Sub-module ts_ch_buf, instantiated N_CH times: assembler FSM, circular RAM, the three pointers, packet count and OVERFLOW bit.
- The top level holds the scheduler and the output registers.

Test Plan:
- Single packet: ch2 sends 188 bytes 47,00..BA; OUT_EN held high -> DATA_OUT reproduces them, P_SYNC_OUT on 47, CH_OUT=2, D_VALID_OUT high for exactly 188 cycles.
- Fairness: all 4 channels hold 2 packets each, OUT_EN continuous -> CH_OUT sequence 0,1,2,3,0,1,2,3 with no gap cycles.
- Early sync: ch1 sends P_SYNC, 100 bytes, then P_SYNC plus 188 bytes -> exactly one packet is output, starting from the second sync byte.
- Overflow: ch0 receives 3 packets with OUT_EN=0 -> packet 3 is dropped, OVERFLOW=4'b0001; enabling OUT_EN then yields 2 packets.
- Pacing/reset: OUT_EN every 3rd cycle gives bytes spaced 3 cycles apart; RST asserted at byte 50 -> D_VALID_OUT=0 the next cycle and buffers are empty afterwards.
- TS_NULL_INSERT_EN defined, no input: OUT_EN high -> repeating 47 1F FF 10 FF.. packets, P_SYNC_OUT every 188 cycles.

Source files
------------

// File: rtl/ts_mux_pkg.sv
// ts_mux_pkg: shared constants, FSM state enums and helpers for the ts_mux_n multiplexer
package ts_mux_pkg;
  localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
  localparam logic [12:0] TS_NULL_PID = 13'h1FFF;
  localparam logic [7:0] TS_NULL_HDR1 = {3'b000, TS_NULL_PID[12:8]};
  localparam logic [7:0] TS_NULL_HDR2 = TS_NULL_PID[7:0];
  localparam logic [7:0] TS_NULL_HDR3 = 8'h10;
  localparam logic [7:0] TS_NULL_FILL = 8'hFF;
  typedef enum logic {ASM_IDLE, ASM_FILL} asm_state_t;
  typedef enum logic {SCH_IDLE, SCH_SEND} sch_state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic logic [7:0] null_byte(input int idx);
    return idx == 0 ? TS_SYNC_BYTE : idx == 1 ? TS_NULL_HDR1 : idx == 2 ? TS_NULL_HDR2 :
           idx == 3 ? TS_NULL_HDR3 : TS_NULL_FILL;
  endfunction
endpackage

// File: rtl/ts_ch_buf.sv
// ts_ch_buf: per-channel packet assembler and circular buffer; only committed packets are readable
module ts_ch_buf import ts_mux_pkg::*; #(
  parameter int PKT_LEN = 188,
  parameter int BUF_PKTS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  input  logic       i_sync,
  input  logic       i_rd,
  input  logic       i_rd_last,
  output logic [7:0] o_rd_data,
  output logic       o_ready,
  output logic       o_overflow
);
  localparam int DEPTH = PKT_LEN * BUF_PKTS;
  localparam int AW = clog2(DEPTH);
  localparam int UW = clog2(DEPTH + 1);
  localparam int CNTW = clog2(PKT_LEN);
  localparam int PW = clog2(BUF_PKTS + 1);
  logic [7:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_cm, r_rd, w_wr_nxt, w_cm_nxt, w_wa;
  logic [UW-1:0] r_used;
  logic [PW-1:0] r_pkts;
  logic [CNTW-1:0] r_cnt, w_cnt_nxt;
  asm_state_t r_st, w_st_nxt;
  logic r_ovf, w_we, w_commit, w_drop, w_space;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  // r_used counts committed, not-yet-read bytes, so free space grows as the scheduler reads
  assign w_space = (UW'(DEPTH) - r_used) >= UW'(PKT_LEN);
  always_comb begin
    w_st_nxt = r_st;
    w_wr_nxt = r_wr;
    w_cm_nxt = r_cm;
    w_cnt_nxt = r_cnt;
    w_wa = r_wr;
    w_we = 1'b0;
    w_commit = 1'b0;
    w_drop = 1'b0;
    if (i_valid && i_sync) begin
      w_wa = r_cm;
      w_we = w_space;
      w_drop = !w_space;
      w_wr_nxt = w_space ? nxt(r_cm) : r_cm;
      w_cnt_nxt = CNTW'(1);
      w_st_nxt = w_space ? ASM_FILL : ASM_IDLE;
    end else if (i_valid && r_st == ASM_FILL) begin
      w_we = 1'b1;
      w_wr_nxt = nxt(r_wr);
      w_commit = r_cnt == CNTW'(PKT_LEN - 1);
      w_cm_nxt = w_commit ? nxt(r_wr) : r_cm;
      w_cnt_nxt = r_cnt + 1'b1;
      w_st_nxt = w_commit ? ASM_IDLE : ASM_FILL;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st <= ASM_IDLE;
      r_wr <= '0;
      r_cm <= '0;
      r_rd <= '0;
      r_cnt <= '0;
      r_used <= '0;
      r_pkts <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_st <= w_st_nxt;
      r_wr <= w_wr_nxt;
      r_cm <= w_cm_nxt;
      r_cnt <= w_cnt_nxt;
      r_rd <= i_rd ? nxt(r_rd) : r_rd;
      r_used <= r_used + (w_commit ? UW'(PKT_LEN) : '0) - UW'(i_rd);
      r_pkts <= r_pkts + PW'(w_commit) - PW'(i_rd_last);
      r_ovf <= r_ovf | w_drop;
    end
  end
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_wa] <= i_data;
  end
  assign o_rd_data = r_mem[r_rd];
  assign o_ready = r_pkts != '0;
  assign o_overflow = r_ovf;
endmodule

// File: rtl/ts_mux_n.sv
// ts_mux_n: N-channel TS packet mux, packet-granular round-robin paced by OUT_EN.
// Define TS_NULL_INSERT_EN to fill idle output slots with null packets.
module ts_mux_n import ts_mux_pkg::*; #(
  parameter int N_CH = 4,
  parameter int PKT_LEN = 188,
  parameter int BUF_PKTS = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [8*N_CH-1:0]        DATA_IN,
  input  logic [N_CH-1:0]          D_VALID_IN,
  input  logic [N_CH-1:0]          P_SYNC_IN,
  input  logic                     OUT_EN,
  output logic [7:0]               DATA_OUT,
  output logic                     D_VALID_OUT,
  output logic                     P_SYNC_OUT,
  output logic [clog2(N_CH)-1:0]   CH_OUT,
  output logic [N_CH-1:0]          OVERFLOW
);
  localparam int CW = clog2(N_CH);
  localparam int BW = clog2(PKT_LEN);
`ifdef TS_NULL_INSERT_EN
  localparam logic NULL_EN = 1'b1;
`else
  localparam logic NULL_EN = 1'b0;
`endif
  logic [7:0] w_rd_data [N_CH];
  logic [N_CH-1:0] w_ready, w_rd;
  sch_state_t r_st, w_st_nxt;
  logic [CW-1:0] r_grant, r_rr, w_found_ch, w_sel;
  logic [BW-1:0] r_bcnt;
  logic [7:0] w_byte;
  logic r_null, w_found, w_emit, w_last, w_null;
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign w_rd[k] = w_emit && !w_null && w_sel == CW'(k);
    ts_ch_buf #(.PKT_LEN(PKT_LEN), .BUF_PKTS(BUF_PKTS)) u_buf (
      .clk(CLK),
      .rst(RST),
      .i_data(DATA_IN[8*k +: 8]),
      .i_valid(D_VALID_IN[k]),
      .i_sync(P_SYNC_IN[k]),
      .i_rd(w_rd[k]),
      .i_rd_last(w_rd[k] && w_last),
      .o_rd_data(w_rd_data[k]),
      .o_ready(w_ready[k]),
      .o_overflow(OVERFLOW[k])
    );
  end
  // Walk offsets high to low so the nearest ready channel after r_rr wins
  always_comb begin
    int j;
    j = 0;
    w_found = 1'b0;
    w_found_ch = r_rr;
    for (int i = N_CH - 1; i >= 0; i--) begin
      j = int'(r_rr) + i;
      j = j >= N_CH ? j - N_CH : j;
      if (w_ready[j]) begin
        w_found = 1'b1;
        w_found_ch = CW'(j);
      end
    end
  end
  always_comb begin
    w_sel = r_st == SCH_IDLE ? w_found_ch : r_grant;
    w_null = r_st == SCH_IDLE ? !w_found && NULL_EN : r_null;
    w_emit = OUT_EN && (r_st == SCH_SEND || w_found || NULL_EN);
    w_last = r_st == SCH_SEND && r_bcnt == BW'(PKT_LEN - 1);
    w_byte = w_null ? null_byte(int'(r_bcnt)) : w_rd_data[w_sel];
    w_st_nxt = !w_emit ? r_st : r_st == SCH_IDLE ? SCH_SEND : w_last ? SCH_IDLE : SCH_SEND;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_st <= SCH_IDLE;
      r_grant <= '0;
      r_rr <= '0;
      r_bcnt <= '0;
      r_null <= 1'b0;
      DATA_OUT <= '0;
      D_VALID_OUT <= 1'b0;
      P_SYNC_OUT <= 1'b0;
      CH_OUT <= '0;
    end else begin
      r_st <= w_st_nxt;
      D_VALID_OUT <= w_emit;
      P_SYNC_OUT <= w_emit && r_st == SCH_IDLE;
      if (w_emit) begin
        DATA_OUT <= w_byte;
        r_bcnt <= w_last ? '0 : r_bcnt + 1'b1;
        if (r_st == SCH_IDLE) begin
          r_grant <= w_sel;
          r_null <= w_null;
          CH_OUT <= w_null ? '0 : w_sel;
        end
        if (w_last && !r_null) r_rr <= r_grant == CW'(N_CH - 1) ? '0 : r_grant + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ts_mux_n.sv
// tb_ts_mux_n: scoreboard bench for ts_mux_n with 4 channels and 188-byte packets
module tb_ts_mux_n;
  localparam int L = 188;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [31:0] DATA_IN = '0;
  logic [3:0] D_VALID_IN = '0;
  logic [3:0] P_SYNC_IN = '0;
  logic OUT_EN = 1'b0;
  logic [7:0] DATA_OUT;
  logic D_VALID_OUT, P_SYNC_OUT;
  logic [1:0] CH_OUT;
  logic [3:0] OVERFLOW;
  typedef struct packed {logic [7:0] d; logic ps; logic [1:0] ch;} exp_t;
  exp_t q[$];
  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  ts_mux_n dut (
    .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN), .D_VALID_IN(D_VALID_IN), .P_SYNC_IN(P_SYNC_IN),
    .OUT_EN(OUT_EN), .DATA_OUT(DATA_OUT), .D_VALID_OUT(D_VALID_OUT), .P_SYNC_OUT(P_SYNC_OUT),
    .CH_OUT(CH_OUT), .OVERFLOW(OVERFLOW)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    OUT_EN = 1'b0;
    D_VALID_IN = '0;
    P_SYNC_IN = '0;
    repeat (3) tick();
    RST = 1'b0;
    q.delete();
  endtask

  function automatic logic [7:0] pbyte(input int i, input int tag);
    return i == 0 ? 8'h47 : 8'(tag + i - 1);
  endfunction

  function automatic logic [7:0] nbyte(input int i);
    return i == 0 ? 8'h47 : i == 1 ? 8'h1F : i == 2 ? 8'hFF : i == 3 ? 8'h10 : 8'hFF;
  endfunction

  task automatic send(input int ch, input int tag, input int len);
    for (int i = 0; i < len; i++) begin
      DATA_IN[8*ch +: 8] = pbyte(i, tag);
      D_VALID_IN[ch] = 1'b1;
      P_SYNC_IN[ch] = i == 0;
      tick();
    end
    D_VALID_IN = '0;
    P_SYNC_IN = '0;
  endtask

  task automatic expect_pkt(input int ch, input int tag);
    for (int i = 0; i < L; i++) q.push_back({pbyte(i, tag), i == 0, 2'(ch)});
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) tick();
    checks++; if (DATA_OUT !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", DATA_OUT); end
    checks++; if (D_VALID_OUT !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", D_VALID_OUT); end
    checks++; if (P_SYNC_OUT !== 1'b0) begin errors++; $display("FAIL reset_psync got=%b exp=0", P_SYNC_OUT); end
    checks++; if (CH_OUT !== 2'd0) begin errors++; $display("FAIL reset_ch got=%0d exp=0", CH_OUT); end
    checks++; if (OVERFLOW !== 4'b0000) begin errors++; $display("FAIL reset_ovf got=%b exp=0000", OVERFLOW); end
    RST = 1'b0;
  endtask

  task automatic test_single_packet();
    int vc, fc, lc;
    exp_t got, e;
    vc = 0; fc = -1; lc = -1;
    do_reset();
    send(2, 0, L);
    expect_pkt(2, 0);
    OUT_EN = 1'b1;
    for (int c = 0; c < 260; c++) begin
      tick();
      if (D_VALID_OUT) begin
        got = {DATA_OUT, P_SYNC_OUT, CH_OUT};
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL single_extra got=%h", got); end
        else begin e = q.pop_front(); if (got !== e) begin errors++; $display("FAIL single_byte%0d got=%h exp=%h", vc, got, e); end end
        if (fc < 0) fc = c;
        lc = c;
        vc++;
      end
    end
    OUT_EN = 1'b0;
    checks++; if (vc != L) begin errors++; $display("FAIL single_count got=%0d exp=%0d", vc, L); end
    checks++; if (lc - fc + 1 != L) begin errors++; $display("FAIL single_span got=%0d exp=%0d", lc - fc + 1, L); end
  endtask

  task automatic test_back_to_back();
    int vc, fc, lc;
    exp_t got, e;
    vc = 0; fc = -1; lc = -1;
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int ch = 0; ch < 4; ch++) send(ch, ch * 40 + p * 20 + 1, L);
    for (int p = 0; p < 2; p++)
      for (int ch = 0; ch < 4; ch++) expect_pkt(ch, ch * 40 + p * 20 + 1);
    OUT_EN = 1'b1;
    for (int c = 0; c < 8 * L + 30; c++) begin
      tick();
      if (D_VALID_OUT) begin
        got = {DATA_OUT, P_SYNC_OUT, CH_OUT};
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL fair_extra got=%h", got); end
        else begin e = q.pop_front(); if (got !== e) begin errors++; $display("FAIL fair_byte%0d got=%h exp=%h", vc, got, e); end end
        if (fc < 0) fc = c;
        lc = c;
        vc++;
      end
    end
    OUT_EN = 1'b0;
    checks++; if (vc != 8 * L) begin errors++; $display("FAIL fair_count got=%0d exp=%0d", vc, 8 * L); end
    checks++; if (lc - fc + 1 != 8 * L) begin errors++; $display("FAIL fair_gap span=%0d exp=%0d", lc - fc + 1, 8 * L); end
  endtask

  task automatic test_early_sync();
    int vc;
    exp_t got, e;
    vc = 0;
    do_reset();
    send(1, 99, 101);
    send(1, 5, L);
    expect_pkt(1, 5);
    OUT_EN = 1'b1;
    for (int c = 0; c < 2 * L + 20; c++) begin
      tick();
      if (D_VALID_OUT) begin
        got = {DATA_OUT, P_SYNC_OUT, CH_OUT};
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL early_extra got=%h", got); end
        else begin e = q.pop_front(); if (got !== e) begin errors++; $display("FAIL early_byte%0d got=%h exp=%h", vc, got, e); end end
        vc++;
      end
    end
    OUT_EN = 1'b0;
    checks++; if (vc != L) begin errors++; $display("FAIL early_count got=%0d exp=%0d", vc, L); end
  endtask

  task automatic test_overflow();
    int vc;
    exp_t got, e;
    vc = 0;
    do_reset();
    send(0, 10, L);
    send(0, 30, L);
    checks++; if (OVERFLOW !== 4'b0000) begin errors++; $display("FAIL ovf_early got=%b exp=0000", OVERFLOW); end
    send(0, 50, L);
    checks++; if (OVERFLOW !== 4'b0001) begin errors++; $display("FAIL ovf_set got=%b exp=0001", OVERFLOW); end
    expect_pkt(0, 10);
    expect_pkt(0, 30);
    OUT_EN = 1'b1;
    for (int c = 0; c < 3 * L + 20; c++) begin
      tick();
      if (D_VALID_OUT) begin
        got = {DATA_OUT, P_SYNC_OUT, CH_OUT};
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL ovf_extra got=%h", got); end
        else begin e = q.pop_front(); if (got !== e) begin errors++; $display("FAIL ovf_byte%0d got=%h exp=%h", vc, got, e); end end
        vc++;
      end
    end
    OUT_EN = 1'b0;
    checks++; if (vc != 2 * L) begin errors++; $display("FAIL ovf_count got=%0d exp=%0d", vc, 2 * L); end
    checks++; if (OVERFLOW !== 4'b0001) begin errors++; $display("FAIL ovf_sticky got=%b exp=0001", OVERFLOW); end
  endtask

  task automatic test_pacing_reset();
    int vc, prev, vc2;
    exp_t got, e;
    vc = 0; prev = -1; vc2 = 0;
    do_reset();
    send(3, 70, L);
    send(3, 90, L);
    expect_pkt(3, 70);
    for (int c = 0; c < 3 * L; c++) begin
      OUT_EN = c % 3 == 0;
      tick();
      if (D_VALID_OUT) begin
        got = {DATA_OUT, P_SYNC_OUT, CH_OUT};
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL pace_extra got=%h", got); end
        else begin e = q.pop_front(); if (got !== e) begin errors++; $display("FAIL pace_byte%0d got=%h exp=%h", vc, got, e); end end
        if (prev >= 0) begin
          checks++;
          if (c - prev != 3) begin errors++; $display("FAIL pace_spacing got=%0d exp=3", c - prev); end
        end
        prev = c;
        vc++;
        if (vc == 50) break;
      end
    end
    checks++; if (vc != 50) begin errors++; $display("FAIL pace_count got=%0d exp=50", vc); end
    RST = 1'b1;
    OUT_EN = 1'b0;
    tick();
    checks++; if (D_VALID_OUT !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", D_VALID_OUT); end
    checks++; if (DATA_OUT !== 8'h00) begin errors++; $display("FAIL rst_data got=%h exp=00", DATA_OUT); end
    RST = 1'b0;
    q.delete();
    OUT_EN = 1'b1;
    for (int c = 0; c < 2 * L; c++) begin
      tick();
      if (D_VALID_OUT) vc2++;
    end
    OUT_EN = 1'b0;
    checks++; if (vc2 != 0) begin errors++; $display("FAIL rst_empty got=%0d bytes exp=0", vc2); end
  endtask

`ifdef TS_NULL_INSERT_EN
  task automatic test_null_insert();
    int vc;
    exp_t got, e;
    vc = 0;
    do_reset();
    for (int i = 0; i < 2 * L; i++) q.push_back({nbyte(i % L), i % L == 0, 2'd0});
    OUT_EN = 1'b1;
    for (int c = 0; c < 2 * L; c++) begin
      tick();
      if (D_VALID_OUT) begin
        got = {DATA_OUT, P_SYNC_OUT, CH_OUT};
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL null_extra got=%h", got); end
        else begin e = q.pop_front(); if (got !== e) begin errors++; $display("FAIL null_byte%0d got=%h exp=%h", vc, got, e); end end
        vc++;
      end
    end
    OUT_EN = 1'b0;
    checks++; if (vc != 2 * L) begin errors++; $display("FAIL null_count got=%0d exp=%0d", vc, 2 * L); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_packet();
    test_back_to_back();
    test_early_sync();
    test_overflow();
    test_pacing_reset();
`ifdef TS_NULL_INSERT_EN
    test_null_insert();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
